// File: rtl/ext_bus_initiator.sv
// ---------------------------------------------------------------------------
// ext_bus_initiator
//
// Initiator (master) end of the external memory bus. One request from the
// core-side memory controller becomes a header word followed by either
// streamed write beats or captured read beats.
//
// Transaction shape on the bus:
//   HDR   : {write, size[1:0], addr[28:0]}, driven by the initiator
//   WDATA : N write beats driven by the initiator (data from IN_wdata)
//   RDATA : N read beats driven by the responder (sampled from IN_bus)
// N = BEATS for a full-line burst (size == 3), otherwise 1. Line bursts start
// at the critical word and wrap within the line.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   IN_reqValid / OUT_reqReady     request handshake
//   IN_reqWrite, IN_reqSize,
//   IN_reqAddr                     request attributes, latched on accept
//   IN_wdata / IN_wdataValid /
//   OUT_wdataReady                 write beat stream from the core
//   OUT_rdata, OUT_rdataAddr,
//   OUT_rdataValid                 captured read beat (one-cycle strobe)
//   OUT_done                       one-cycle pulse after the last beat
//   OUT_busOE, OUT_bus             bus drive enable and drive value
//   IN_bus                         bus sampled value
//   IN_busReady / OUT_busValid     bus beat handshake
//   OUT_dbgState                   current FSM state (IDLE/HDR/WDATA/RDATA)
//
// Handshake semantics (all three interfaces): a transfer happens on a rising
// edge where valid && ready are both 1. A source holding valid without ready
// keeps its payload stable; ready may rise or fall on any cycle.
//
// The header layout is fixed at 32 bits, so WIDTH must be 32.
// ---------------------------------------------------------------------------
module ext_bus_initiator #(
  parameter int WIDTH    = 32,
  parameter int CLSIZE_E = 6
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             IN_reqValid,
  output logic             OUT_reqReady,
  input  logic             IN_reqWrite,
  input  logic [1:0]       IN_reqSize,
  input  logic [28:0]      IN_reqAddr,

  input  logic [WIDTH-1:0] IN_wdata,
  input  logic             IN_wdataValid,
  output logic             OUT_wdataReady,

  output logic [WIDTH-1:0] OUT_rdata,
  output logic [28:0]      OUT_rdataAddr,
  output logic             OUT_rdataValid,
  output logic             OUT_done,

  output logic             OUT_busOE,
  output logic [WIDTH-1:0] OUT_bus,
  input  logic [WIDTH-1:0] IN_bus,
  input  logic             IN_busReady,
  output logic             OUT_busValid,

  output logic [1:0]       OUT_dbgState
);

  // Word index within a line and burst length.
  localparam int                IDX_W    = CLSIZE_E - 2;
  localparam int                BEATS    = 1 << IDX_W;
  localparam logic [IDX_W-1:0]  CNT_LAST = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HDR   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_e;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic               write_q,       write_d;
  logic [1:0]         size_q,        size_d;
  logic [28:0]        addr_q,        addr_d;
  logic [IDX_W-1:0]   cnt_q,         cnt_d;
  logic [WIDTH-1:0]   rdata_q,       rdata_d;
  logic [28:0]        rdata_addr_q,  rdata_addr_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               done_q,        done_d;

  // Combinational outputs, driven from the FSM process.
  logic               req_ready;
  logic               wdata_ready;
  logic               bus_oe;
  logic               bus_valid;
  logic [WIDTH-1:0]   bus_val;
  logic               data_beat;

  // Next address inside the line: only the word index advances, and it wraps
  // so a burst that starts mid-line returns to the line base.
  logic [IDX_W-1:0]   word_idx_nxt;
  logic [28:0]        addr_nxt;

  assign word_idx_nxt = addr_q[CLSIZE_E-1:2] + IDX_W'(1);
  assign addr_nxt     = {addr_q[28:CLSIZE_E], word_idx_nxt, addr_q[1:0]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      write_q       <= 1'b0;
      size_q        <= 2'd0;
      addr_q        <= '0;
      cnt_q         <= '0;
      rdata_q       <= '0;
      rdata_addr_q  <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_addr_q  <= rdata_addr_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    size_d        = size_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rdata_addr_d  = rdata_addr_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;

    req_ready     = 1'b0;
    wdata_ready   = 1'b0;
    bus_oe        = 1'b0;
    bus_valid     = 1'b0;
    bus_val       = '0;
    data_beat     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (IN_reqValid) begin
          write_d = IN_reqWrite;
          size_d  = IN_reqSize;
          addr_d  = IN_reqAddr;
          // A single-beat access starts on the final count so that its one
          // data beat is also the last beat.
          cnt_d   = (IN_reqSize == 2'd3) ? '0 : CNT_LAST;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        bus_oe    = 1'b1;
        bus_valid = 1'b1;
        bus_val   = WIDTH'({write_q, size_q, addr_q});
        if (IN_busReady) begin
          state_d = write_q ? S_WDATA : S_RDATA;
        end
      end

      S_WDATA: begin
        bus_oe      = 1'b1;
        bus_val     = IN_wdata;
        bus_valid   = IN_wdataValid;
        wdata_ready = IN_busReady;
        data_beat   = IN_wdataValid && IN_busReady;
      end

      S_RDATA: begin
        // The responder owns the bus for the whole data phase, including the
        // first cycle, so the initiator releases it immediately.
        bus_valid = 1'b1;
        data_beat = IN_busReady;
        if (IN_busReady) begin
          rdata_d       = IN_bus;
          rdata_addr_d  = addr_q;
          rdata_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (data_beat) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (size_q == 2'd3) begin
        addr_d = addr_nxt;
      end
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The request port is closed while reset is asserted even though the FSM
  // already sits in IDLE.
  assign OUT_reqReady   = req_ready && rst;
  assign OUT_wdataReady = wdata_ready;
  assign OUT_busOE      = bus_oe;
  assign OUT_busValid   = bus_valid;
  assign OUT_bus        = bus_val;
  assign OUT_rdata      = rdata_q;
  assign OUT_rdataAddr  = rdata_addr_q;
  assign OUT_rdataValid = rdata_valid_q;
  assign OUT_done       = done_q;
  assign OUT_dbgState   = state_q;

endmodule

// File: tb/tb_ext_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_ext_bus_initiator
//
// Directed bench for ext_bus_initiator. The stimulus process issues requests
// and pushes the expected bus beats and read results into queues; a monitor
// process running on the falling edge pops and compares them whenever the DUT
// transfers a bus beat, strobes read data or pulses done. The monitor also
// plays the bus responder: it decodes the read header and returns
// {3'b101, word address} for each read beat.
// ---------------------------------------------------------------------------
module tb_ext_bus_initiator;

  logic        clk;
  logic        rst;
  logic        IN_reqValid;
  logic        OUT_reqReady;
  logic        IN_reqWrite;
  logic [1:0]  IN_reqSize;
  logic [28:0] IN_reqAddr;
  logic [31:0] IN_wdata;
  logic        IN_wdataValid;
  logic        OUT_wdataReady;
  logic [31:0] OUT_rdata;
  logic [28:0] OUT_rdataAddr;
  logic        OUT_rdataValid;
  logic        OUT_done;
  logic        OUT_busOE;
  logic [31:0] OUT_bus;
  logic [31:0] IN_bus;
  logic        IN_busReady;
  logic        OUT_busValid;
  logic [1:0]  OUT_dbgState;

  ext_bus_initiator #(.WIDTH(32), .CLSIZE_E(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_reqValid    (IN_reqValid),
    .OUT_reqReady   (OUT_reqReady),
    .IN_reqWrite    (IN_reqWrite),
    .IN_reqSize     (IN_reqSize),
    .IN_reqAddr     (IN_reqAddr),
    .IN_wdata       (IN_wdata),
    .IN_wdataValid  (IN_wdataValid),
    .OUT_wdataReady (OUT_wdataReady),
    .OUT_rdata      (OUT_rdata),
    .OUT_rdataAddr  (OUT_rdataAddr),
    .OUT_rdataValid (OUT_rdataValid),
    .OUT_done       (OUT_done),
    .OUT_busOE      (OUT_busOE),
    .OUT_bus        (OUT_bus),
    .IN_bus         (IN_bus),
    .IN_busReady    (IN_busReady),
    .OUT_busValid   (OUT_busValid),
    .OUT_dbgState   (OUT_dbgState)
  );

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Bus beat entry: {b2b_hdr, hdr, last, oe, data[31:0]}
  logic [35:0] bus_exp_q[$];
  // Read result entry: {addr[28:0], data[31:0]}
  logic [60:0] rd_exp_q[$];

  logic [28:0] rsp_addr  = '0;
  bit          rsp_line  = 1'b0;
  bit          rd_taken  = 1'b0;
  bit          done_due  = 1'b0;
  bit          txn_open  = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_bus  = '0;
  int          last_cyc  = 0;
  int          rd_seen   = 0;

  assign IN_bus = {3'b101, rsp_addr};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busOE"},       OUT_busOE,       0);
    chk({tag, "_busValid"},    OUT_busValid,    0);
    chk({tag, "_reqReady"},    OUT_reqReady,    0);
    chk({tag, "_wdataReady"},  OUT_wdataReady,  0);
    chk({tag, "_rdataValid"},  OUT_rdataValid,  0);
    chk({tag, "_done"},        OUT_done,        0);
    chk({tag, "_bus"},         OUT_bus,         0);
    chk({tag, "_rdata"},       OUT_rdata,       0);
    chk({tag, "_rdataAddr"},   OUT_rdataAddr,   0);
  endtask

  // -------------------------------------------------------------------------
  // Monitor / responder
  // -------------------------------------------------------------------------
  initial begin
    logic [35:0] be;
    logic [60:0] re;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        bus_exp_q.delete();
        rd_exp_q.delete();
        done_due   = 1'b0;
        txn_open   = 1'b0;
        rd_taken   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        // Responder moves to the next word once the previous read beat has
        // been sampled on the rising edge.
        if (rd_taken) begin
          if (rsp_line) rsp_addr = {rsp_addr[28:6], rsp_addr[5:2] + 4'd1, rsp_addr[1:0]};
          rd_taken = 1'b0;
        end

        if (OUT_done || done_due) chk("done_pulse", OUT_done, done_due);
        done_due = 1'b0;

        if (OUT_rdataValid) begin
          rd_seen++;
          if (rd_exp_q.size() == 0) begin
            chk("rdata_unexpected_strobe", 1, 0);
          end else begin
            re = rd_exp_q.pop_front();
            chk("rdata", OUT_rdata, re[31:0]);
            chk("rdata_addr", OUT_rdataAddr, re[60:32]);
          end
        end

        if (txn_open) chk("req_ready_busy", OUT_reqReady, 0);
        if (IN_reqValid && OUT_reqReady) txn_open = 1'b1;

        if (prev_stall && OUT_busOE) begin
          chk("stall_valid_held", OUT_busValid, 1);
          chk("stall_bus_held", OUT_bus, prev_bus);
        end
        prev_stall = OUT_busValid && !IN_busReady;
        prev_bus   = OUT_bus;

        if (OUT_busValid && IN_busReady) begin
          if (bus_exp_q.size() == 0) begin
            chk("bus_unexpected_beat", 1, 0);
          end else begin
            be = bus_exp_q.pop_front();
            chk("bus_oe", OUT_busOE, be[32]);
            if (be[32]) chk("bus_data", OUT_bus, be[31:0]);
            if (be[35]) chk("b2b_hdr_gap", cyc - last_cyc, 2);
            if (be[34]) begin
              rsp_addr = OUT_bus[28:0];
              rsp_line = (OUT_bus[30:29] == 2'b11);
            end else if (!be[32]) begin
              rd_taken = 1'b1;
            end
            if (be[33]) begin
              done_due = 1'b1;
              last_cyc = cyc;
              txn_open = 1'b0;
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic issue_req(input bit w, input logic [1:0] sz, input logic [28:0] a,
                           input logic [31:0] hdr, input logic [31:0] wbase, input bit b2b);
    int          n;
    logic [28:0] ak;
    bit          ok;
    n = (sz == 2'd3) ? 16 : 1;
    bus_exp_q.push_back({b2b, 1'b1, 1'b0, 1'b1, hdr});
    for (int k = 0; k < n; k++) begin
      ak = (sz == 2'd3) ? {a[28:6], 4'(a[5:2] + k), a[1:0]} : a;
      if (w) begin
        bus_exp_q.push_back({1'b0, 1'b0, (k == n - 1), 1'b1, wbase + 32'(k)});
      end else begin
        bus_exp_q.push_back({1'b0, 1'b0, (k == n - 1), 1'b0, 32'h0});
        rd_exp_q.push_back({ak, 3'b101, ak});
      end
    end
    IN_reqValid = 1'b1;
    IN_reqWrite = w;
    IN_reqSize  = sz;
    IN_reqAddr  = a;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (OUT_reqReady) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    IN_reqValid = 1'b0;
    chk("req_accept", ok, 1);
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (bus_exp_q.size() == 0 && rd_exp_q.size() == 0 && !done_due) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk(name, ok, 1);
  endtask

  // Line write data with the bus ready toggling every cycle and a one-cycle
  // data bubble after every third consumed beat.
  task automatic drive_line_write(input logic [31:0] base);
    int k;
    bit rdy;
    bit bub;
    k   = 0;
    rdy = 1'b0;
    bub = 1'b0;
    for (int c = 0; c < 300 && k < 16; c++) begin
      IN_busReady = rdy;
      rdy = !rdy;
      if (bub) begin
        IN_wdataValid = 1'b0;
        bub = 1'b0;
      end else begin
        IN_wdataValid = 1'b1;
        IN_wdata      = base + 32'(k);
      end
      @(negedge clk);
      if (IN_wdataValid && OUT_wdataReady) begin
        k++;
        bub = (k % 3 == 0);
      end
      @(posedge clk);
      #1;
    end
    chk("t3_beats_consumed", k, 16);
    IN_busReady   = 1'b1;
    IN_wdataValid = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int base;
    bit ok;
    rst           = 1'b0;
    IN_reqValid   = 1'b0;
    IN_reqWrite   = 1'b0;
    IN_reqSize    = 2'd0;
    IN_reqAddr    = '0;
    IN_wdata      = '0;
    IN_wdataValid = 1'b0;
    IN_busReady   = 1'b1;

    #3;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", OUT_reqReady, 1);
    chk("idle_state", OUT_dbgState, 0);
    chk("idle_bus_oe", OUT_busOE, 0);
    @(posedge clk);
    #1;

    // 1: single-word write
    IN_wdata      = 32'h0000_0041;
    IN_wdataValid = 1'b1;
    issue_req(1'b1, 2'd0, 29'h1000_0000, 32'h9000_0000, 32'h0000_0041, 1'b0);
    wait_drain("t1_drain");
    IN_wdataValid = 1'b0;

    // 2: line read starting at the critical word 0x48
    issue_req(1'b0, 2'd3, 29'h0000_0048, 32'h6000_0048, 32'h0, 1'b0);
    wait_drain("t2_drain");

    // 3: line write with ready toggling and data bubbles
    issue_req(1'b1, 2'd3, 29'h0000_0208, 32'hE000_0208, 32'hC0DE_0000, 1'b0);
    drive_line_write(32'hC0DE_0000);
    wait_drain("t3_drain");

    // 4: reset in the middle of a line read
    base = rd_seen;
    issue_req(1'b0, 2'd3, 29'h0000_0100, 32'h6000_0100, 32'h0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (rd_seen >= base + 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_reached_beat5", ok, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("t4_abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_no_done_after_release", OUT_done, 0);
    @(posedge clk);
    #1;
    issue_req(1'b0, 2'd3, 29'h0000_0000, 32'h6000_0000, 32'h0, 1'b0);
    wait_drain("t4_drain");

    // 5: line read immediately followed by a single write
    IN_wdata      = 32'h0000_005A;
    IN_wdataValid = 1'b1;
    issue_req(1'b0, 2'd3, 29'h0000_0080, 32'h6000_0080, 32'h0, 1'b0);
    issue_req(1'b1, 2'd0, 29'h1000_0000, 32'h9000_0000, 32'h0000_005A, 1'b1);
    wait_drain("t5_drain");
    IN_wdataValid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_bus_q_empty", bus_exp_q.size(), 0);
    chk("final_rd_q_empty", rd_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_bus_initiator.md
Name: ext_bus_initiator

Overview:
Initiator (master) end of the external memory bus. It turns one cache-line or single-word request from the core-side memory controller into a header word plus data beats on the shared bus. It streams write data out, or captures read data returned by the bus responder. It sits between the core's memory interface and the external bus memory/MMIO responder.

Parameters:
WIDTH, 32, bus width; the header format requires exactly 32.
CLSIZE_E, 6, log2 of cache-line size in bytes; burst length BEATS = 2^(CLSIZE_E-2).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
IN_reqValid  in  1  request present.
OUT_reqReady  out  1  request accepted when IN_reqValid && OUT_reqReady.
IN_reqWrite  in  1  1 = write, 0 = read.
IN_reqSize  in  2  3 = full-line burst; 0..2 = single-beat access.
IN_reqAddr  in  29  byte address; the line offset selects the critical word.
IN_wdata  in  WIDTH  write beat data.
IN_wdataValid  in  1  write beat available.
OUT_wdataReady  out  1  write beat consumed when IN_wdataValid && OUT_wdataReady.
OUT_rdata  out  WIDTH  captured read beat.
OUT_rdataAddr  out  29  byte address of OUT_rdata.
OUT_rdataValid  out  1  one-cycle strobe per read beat.
OUT_done  out  1  one-cycle pulse after the last beat of a transaction.
OUT_busOE  out  1  initiator drives the bus.
OUT_bus  out  WIDTH  bus drive value.
IN_bus  in  WIDTH  bus sampled value (responder-driven during reads).
IN_busReady  in  1  responder ready for a beat.
OUT_busValid  out  1  initiator offers or requests a beat.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counters 0. Outputs: OUT_busOE=0, OUT_busValid=0, OUT_reqReady=0, OUT_wdataReady=0, OUT_rdataValid=0, OUT_done=0, OUT_bus=0, OUT_rdata=0, OUT_rdataAddr=0.
- Reset mid-transaction aborts immediately, with no OUT_done and no further beats.
- Handshakes: a bus beat transfers on any rising edge with OUT_busValid && IN_busReady. IN_busReady may drop on any cycle; a stalled beat holds all of its values.
- States:
  - IDLE: OUT_reqReady=1. On accept, latch write/size/addr. Set cnt = (size==3) ? 0 : BEATS-1. Go to HDR.
  - HDR: OUT_busOE=1, OUT_busValid=1, OUT_bus = {write, size[1:0], addr[28:0]}. On beat: write -> WDATA, read -> RDATA.
  - WDATA: OUT_busOE=1, OUT_bus=IN_wdata, OUT_busValid=IN_wdataValid, OUT_wdataReady=IN_busReady. A write bubble (IN_wdataValid=0) holds the state.
  - RDATA: OUT_busOE=0 from the first RDATA cycle (the responder drives the bus that same cycle), OUT_busValid=1. On each beat, next cycle OUT_rdata=IN_bus as sampled, OUT_rdataAddr=current addr, OUT_rdataValid=1.
- Per beat in WDATA/RDATA: cnt += 1. Advance addr = {addr[28:CLSIZE_E], addr[CLSIZE_E-1:2]+1 (wraps within the line), addr[1:0]}.
- Last beat is the beat taken with cnt == BEATS-1. Next state IDLE, and OUT_done=1 in the following cycle.
- Single-beat requests (size 0..2) move exactly one data beat with the address unchanged.
- Back-to-back: OUT_reqReady returns the cycle after the last beat. A new header can go out 2 cycles after the previous last beat (IDLE, then HDR). OUT_done of the old transaction coincides with the IDLE cycle.
- OUT_busOE is never 1 in IDLE or RDATA, so the bus is never double-driven.

Test Plan:
1. Write, size 0, addr 0x10000000, wdata 0x41, ready always 1 -> header 0x90000000 then one beat 0x00000041; OUT_done 1 cycle later; 2 bus beats total.
2. Read, size 3, addr 0x00000048, CLSIZE_E=6 -> header 0x60000048; 16 OUT_rdataValid strobes with addrs 0x48,0x4C,...,0x7C,0x40,0x44; OUT_busOE=0 throughout RDATA; one OUT_done.
3. Line write, with IN_busReady toggling 1,0,1,0 and IN_wdataValid bubbles -> exactly 16 beats consumed in order; OUT_bus stable while stalled; no duplicated or lost beats.
4. rst pulled low at read beat 5 -> all outputs at reset values asynchronously, no OUT_done; after release, a new read to 0x0 completes normally.
5. Two requests back-to-back (line read, then single write to 0x10000000) -> second header appears 2 cycles after the first's last beat; OUT_reqReady is 0 for the whole first transaction.
